// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_ctrl_pkg : shared load codes, bus widths and FSM state encoding |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package pipe_ctrl_pkg;

  localparam int BUS_L_CODE   = 3;
  localparam int BUS_ADDR_REG = 5;

  localparam logic [BUS_L_CODE-1:0] LOAD_NOPE = 3'd0;
  localparam logic [BUS_L_CODE-1:0] LOAD_LB   = 3'd1;
  localparam logic [BUS_L_CODE-1:0] LOAD_LH   = 3'd2;
  localparam logic [BUS_L_CODE-1:0] LOAD_LW   = 3'd3;
  localparam logic [BUS_L_CODE-1:0] LOAD_LBU  = 3'd4;
  localparam logic [BUS_L_CODE-1:0] LOAD_LHU  = 3'd5;

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_MC_WAIT = 1'b1
  } state_e;

  // Stage register write enables; a 1 lets the stage advance.
  typedef struct packed {
    logic pc;
    logic if_id;
    logic id_ex;
    logic ex_mem;
    logic mem_wb;
  } hold_n_t;

  typedef struct packed {
    logic if_id;
    logic id_ex;
    logic ex_mem;
  } flush_t;

  localparam hold_n_t c_hold_n_run  = 5'b11111;
  localparam hold_n_t c_hold_n_mem  = 5'b00000;
  localparam hold_n_t c_hold_n_mc   = 5'b00011;
  localparam hold_n_t c_hold_n_lu   = 5'b00111;

  localparam flush_t  c_flush_none  = 3'b000;
  localparam flush_t  c_flush_jump  = 3'b110;
  localparam flush_t  c_flush_lu    = 3'b010;
  localparam flush_t  c_flush_mc    = 3'b001;

  function automatic logic src_hazard(
    input logic [BUS_ADDR_REG-1:0] rd,
    input logic [BUS_ADDR_REG-1:0] rs,
    input logic                    used
  );
    return used && (rs == rd);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_sat_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_sat_cnt : saturating up-counter with sync clear and enable      |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module pipe_sat_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_ctrl : pipeline hold/flush control for memory, multi-cycle,     |
// |             jump and load-use hazards, with stall statistics         |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [BUS_L_CODE-1:0]   ex_load_code,
  input  logic [BUS_ADDR_REG-1:0] ex_addr_rd,
  input  logic                    ex_reg_wr_en,
  input  logic [BUS_ADDR_REG-1:0] id_addr_rs1,
  input  logic [BUS_ADDR_REG-1:0] id_addr_rs2,
  input  logic                    id_rs1_used,
  input  logic                    id_rs2_used,
  input  logic                    ex_jump_flag,
  input  logic                    ex_mc_req,
  input  logic                    ex_mc_done,
  input  logic                    mem_req,
  input  logic                    mem_ready,
  output logic                    hold_n_pc,
  output logic                    hold_n_if_id,
  output logic                    hold_n_id_ex,
  output logic                    hold_n_ex_mem,
  output logic                    hold_n_mem_wb,
  output logic                    flush_if_id,
  output logic                    flush_id_ex,
  output logic                    flush_ex_mem,
  output logic                    mc_timeout,
  output logic [CNT_W-1:0]        stall_cnt
);

  localparam int TMO_W = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] c_tmo_last = TMO_W'(MC_TIMEOUT - 1);

  state_e           state_d;
  state_e           state_q;
  hold_n_t          hold_n;
  flush_t           flush;
  logic             tmo_pulse;
  logic             tmo_clr;
  logic             tmo_en;
  logic [TMO_W-1:0] tmo_cnt;
  logic             mem_wait;
  logic             load_use;
  logic             tmo_hit;

  assign mem_wait = mem_req && !mem_ready;

  // x0 is hardwired to zero, so a load targeting it never creates a hazard.
  assign load_use = (ex_load_code != LOAD_NOPE) && ex_reg_wr_en &&
                    (ex_addr_rd != '0) &&
                    (src_hazard(ex_addr_rd, id_addr_rs1, id_rs1_used) ||
                     src_hazard(ex_addr_rd, id_addr_rs2, id_rs2_used));

  assign tmo_hit = (tmo_cnt == c_tmo_last);

  always_comb begin
    state_d   = state_q;
    hold_n    = c_hold_n_run;
    flush     = c_flush_none;
    tmo_pulse = 1'b0;
    tmo_clr   = 1'b0;
    if (rst) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          // A pending memory access freezes EX, so MC entry waits until it ends.
          if (!mem_wait) begin
            if (ex_mc_req && !ex_mc_done) begin
              state_d = ST_MC_WAIT;
              tmo_clr = 1'b1;
              hold_n  = c_hold_n_mc;
              flush   = c_flush_mc;
            end else if (ex_jump_flag) begin
              flush   = c_flush_jump;
            end else if (load_use) begin
              hold_n  = c_hold_n_lu;
              flush   = c_flush_lu;
            end
          end
        end
        ST_MC_WAIT: begin
          if (ex_mc_done) begin
            state_d   = ST_RUN;
          end else if (tmo_hit) begin
            state_d   = ST_RUN;
            tmo_pulse = 1'b1;
          end else begin
            hold_n    = c_hold_n_mc;
            flush     = c_flush_mc;
          end
        end
        default: state_d = ST_RUN;
      endcase
      if (mem_wait) begin
        hold_n = c_hold_n_mem;
        flush  = c_flush_none;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign tmo_en = (state_q == ST_MC_WAIT);

  pipe_sat_cnt #(
    .WIDTH (TMO_W)
  ) u_tmo_cnt (
    .clk (clk),
    .rst (rst),
    .clr (tmo_clr),
    .en  (tmo_en),
    .cnt (tmo_cnt)
  );

  pipe_sat_cnt #(
    .WIDTH (CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .en  (!hold_n.pc),
    .cnt (stall_cnt)
  );

  assign hold_n_pc     = hold_n.pc;
  assign hold_n_if_id  = hold_n.if_id;
  assign hold_n_id_ex  = hold_n.id_ex;
  assign hold_n_ex_mem = hold_n.ex_mem;
  assign hold_n_mem_wb = hold_n.mem_wb;
  assign flush_if_id   = flush.if_id;
  assign flush_id_ex   = flush.id_ex;
  assign flush_ex_mem  = flush.ex_mem;
  assign mc_timeout    = tmo_pulse;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pipe_ctrl : directed scoreboard bench for pipe_ctrl               |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int MC_TIMEOUT = 8;
  localparam int CNT_W      = 4;

  localparam logic [4:0] H_ALL  = 5'b11111;
  localparam logic [4:0] H_NONE = 5'b00000;
  localparam logic [4:0] H_LU   = 5'b00111;
  localparam logic [4:0] H_MC   = 5'b00011;
  localparam logic [2:0] F_NO   = 3'b000;
  localparam logic [2:0] F_J    = 3'b110;
  localparam logic [2:0] F_LU   = 3'b010;
  localparam logic [2:0] F_MC   = 3'b001;

  logic                    clk;
  logic                    rst;
  logic [BUS_L_CODE-1:0]   ex_load_code;
  logic [BUS_ADDR_REG-1:0] ex_addr_rd;
  logic                    ex_reg_wr_en;
  logic [BUS_ADDR_REG-1:0] id_addr_rs1;
  logic [BUS_ADDR_REG-1:0] id_addr_rs2;
  logic                    id_rs1_used;
  logic                    id_rs2_used;
  logic                    ex_jump_flag;
  logic                    ex_mc_req;
  logic                    ex_mc_done;
  logic                    mem_req;
  logic                    mem_ready;
  logic                    hold_n_pc;
  logic                    hold_n_if_id;
  logic                    hold_n_id_ex;
  logic                    hold_n_ex_mem;
  logic                    hold_n_mem_wb;
  logic                    flush_if_id;
  logic                    flush_id_ex;
  logic                    flush_ex_mem;
  logic                    mc_timeout;
  logic [CNT_W-1:0]        stall_cnt;

  typedef struct {
    string      name;
    logic [4:0] hold;
    logic [2:0] flush;
    logic       tmo;
    logic [3:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks;
  int   failures;

  pipe_ctrl #(
    .MC_TIMEOUT (MC_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ex_load_code  (ex_load_code),
    .ex_addr_rd    (ex_addr_rd),
    .ex_reg_wr_en  (ex_reg_wr_en),
    .id_addr_rs1   (id_addr_rs1),
    .id_addr_rs2   (id_addr_rs2),
    .id_rs1_used   (id_rs1_used),
    .id_rs2_used   (id_rs2_used),
    .ex_jump_flag  (ex_jump_flag),
    .ex_mc_req     (ex_mc_req),
    .ex_mc_done    (ex_mc_done),
    .mem_req       (mem_req),
    .mem_ready     (mem_ready),
    .hold_n_pc     (hold_n_pc),
    .hold_n_if_id  (hold_n_if_id),
    .hold_n_id_ex  (hold_n_id_ex),
    .hold_n_ex_mem (hold_n_ex_mem),
    .hold_n_mem_wb (hold_n_mem_wb),
    .flush_if_id   (flush_if_id),
    .flush_id_ex   (flush_id_ex),
    .flush_ex_mem  (flush_ex_mem),
    .mc_timeout    (mc_timeout),
    .stall_cnt     (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are combinational on the inputs driven just after posedge,
  // so the mid-cycle sample pairs with the expectation pushed that cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      checks++;
      if ({hold_n_pc, hold_n_if_id, hold_n_id_ex, hold_n_ex_mem, hold_n_mem_wb,
           flush_if_id, flush_id_ex, flush_ex_mem, mc_timeout, stall_cnt} !==
          {mon_e.hold, mon_e.flush, mon_e.tmo, mon_e.cnt}) begin
        failures++;
        $display("FAIL %s: got hold_n=%b flush=%b tmo=%b cnt=%0d, want hold_n=%b flush=%b tmo=%b cnt=%0d",
                 mon_e.name,
                 {hold_n_pc, hold_n_if_id, hold_n_id_ex, hold_n_ex_mem, hold_n_mem_wb},
                 {flush_if_id, flush_id_ex, flush_ex_mem}, mc_timeout, stall_cnt,
                 mon_e.hold, mon_e.flush, mon_e.tmo, mon_e.cnt);
      end
    end
  end

  task automatic idle_inputs();
    ex_load_code = LOAD_NOPE;
    ex_addr_rd   = '0;
    ex_reg_wr_en = 1'b0;
    id_addr_rs1  = '0;
    id_addr_rs2  = '0;
    id_rs1_used  = 1'b0;
    id_rs2_used  = 1'b0;
    ex_jump_flag = 1'b0;
    ex_mc_req    = 1'b0;
    ex_mc_done   = 1'b0;
    mem_req      = 1'b0;
    mem_ready    = 1'b0;
  endtask

  task automatic set_load_use();
    ex_load_code = LOAD_LW;
    ex_addr_rd   = 5'd5;
    ex_reg_wr_en = 1'b1;
    id_addr_rs1  = 5'd3;
    id_rs1_used  = 1'b1;
    id_addr_rs2  = 5'd5;
    id_rs2_used  = 1'b1;
  endtask

  task automatic step(input string name, input logic [4:0] h, input logic [2:0] f,
                      input logic t, input int c);
    exp_t e;
    e.name  = name;
    e.hold  = h;
    e.flush = f;
    e.tmo   = t;
    e.cnt   = 4'(c);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    step("reset", H_ALL, F_NO, 1'b0, 0);
    rst = 1'b0;
    step("idle", H_ALL, F_NO, 1'b0, 0);

    // Load-use detection and its qualifiers
    set_load_use();
    step("lu_rs2", H_LU, F_LU, 1'b0, 0);
    idle_inputs();
    step("lu_release", H_ALL, F_NO, 1'b0, 1);
    set_load_use();
    ex_addr_rd  = 5'd0;
    id_addr_rs1 = 5'd0;
    id_addr_rs2 = 5'd0;
    step("lu_x0", H_ALL, F_NO, 1'b0, 1);
    ex_addr_rd  = 5'd7;
    id_addr_rs1 = 5'd7;
    id_rs1_used = 1'b0;
    id_addr_rs2 = 5'd2;
    step("lu_unused", H_ALL, F_NO, 1'b0, 1);
    id_rs1_used  = 1'b1;
    ex_reg_wr_en = 1'b0;
    step("lu_no_wr", H_ALL, F_NO, 1'b0, 1);
    ex_reg_wr_en = 1'b1;
    ex_load_code = LOAD_NOPE;
    step("lu_nope", H_ALL, F_NO, 1'b0, 1);
    ex_load_code = LOAD_LB;
    step("lu_rs1", H_LU, F_LU, 1'b0, 1);
    ex_jump_flag = 1'b1;
    step("jmp_lu", H_ALL, F_J, 1'b0, 2);
    idle_inputs();
    step("jmp_release", H_ALL, F_NO, 1'b0, 2);

    // Multi-cycle op finishing after 5 cycles
    ex_mc_req = 1'b1;
    step("mc_enter", H_MC, F_MC, 1'b0, 2);
    ex_mc_req = 1'b0;
    for (int i = 1; i <= 4; i++) step("mc_wait", H_MC, F_MC, 1'b0, 2 + i);
    ex_mc_done = 1'b1;
    step("mc_done", H_ALL, F_NO, 1'b0, 7);
    idle_inputs();
    step("mc_release", H_ALL, F_NO, 1'b0, 7);
    ex_mc_req  = 1'b1;
    ex_mc_done = 1'b1;
    step("mc_same", H_ALL, F_NO, 1'b0, 7);
    idle_inputs();
    step("mc_same_run", H_ALL, F_NO, 1'b0, 7);

    // Timeout: pulse on the 8th MC_WAIT cycle
    ex_mc_req = 1'b1;
    step("tmo_enter", H_MC, F_MC, 1'b0, 7);
    ex_mc_req = 1'b0;
    for (int i = 1; i <= 7; i++) step("tmo_wait", H_MC, F_MC, 1'b0, 7 + i);
    step("tmo_pulse", H_ALL, F_NO, 1'b1, 15);
    step("tmo_run", H_ALL, F_NO, 1'b0, 15);

    // Reset during MC_WAIT suppresses the pulse
    ex_mc_req = 1'b1;
    step("t2_enter", H_MC, F_MC, 1'b0, 15);
    ex_mc_req = 1'b0;
    for (int i = 1; i <= 3; i++) step("t2_wait", H_MC, F_MC, 1'b0, 15);
    rst = 1'b1;
    step("t2_reset", H_ALL, F_NO, 1'b0, 15);
    rst = 1'b0;
    for (int i = 5; i <= 10; i++) step("t2_after", H_ALL, F_NO, 1'b0, 0);

    // Jump deferred behind a memory wait
    mem_req      = 1'b1;
    ex_jump_flag = 1'b1;
    for (int i = 0; i < 3; i++) step("mem_wait_jmp", H_NONE, F_NO, 1'b0, i);
    mem_ready = 1'b1;
    step("mem_ready_jmp", H_ALL, F_J, 1'b0, 3);
    idle_inputs();
    step("mem_idle", H_ALL, F_NO, 1'b0, 3);

    // MC entry blocked while memory waits
    mem_req   = 1'b1;
    ex_mc_req = 1'b1;
    step("mem_mc_block", H_NONE, F_NO, 1'b0, 3);
    mem_req = 1'b0;
    step("mem_mc_enter", H_MC, F_MC, 1'b0, 4);
    ex_mc_req  = 1'b0;
    ex_mc_done = 1'b1;
    step("mem_mc_done", H_ALL, F_NO, 1'b0, 5);

    // Long memory wait with a load-use present: saturation, no flush
    idle_inputs();
    set_load_use();
    mem_req = 1'b1;
    for (int i = 0; i < 14; i++)
      step("sat_mem", H_NONE, F_NO, 1'b0, (5 + i > 15) ? 15 : 5 + i);
    idle_inputs();
    step("sat_hold", H_ALL, F_NO, 1'b0, 15);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    if (sb_q.size() > 0) begin
      failures++;
      $display("FAIL drain: got %0d pending, want 0", sb_q.size());
    end
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
